// File: rtl/cpu_step_controller.sv
// Clock-enable sequencer for the 8-bit computer: debounced run/stop and single-step buttons, HLT latch.
// Optional macro CYCLE_COUNTER_EN enables the 16-bit cpu_ce_o pulse counter on cycle_count_o.
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 200_000,
  parameter int RUN_DIV         = 1_200_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run_i,
  input  logic        btn_step_i,
  input  logic        cpu_halt_i,
  output logic        cpu_ce_o,
  output logic        running_o,
  output logic        halted_o,
  output logic [15:0] cycle_count_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  logic [1:0]       btn_raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       stable;
  logic [1:0]       stable_d;
  logic [1:0]       press;
  logic [CNT_W-1:0] db_cnt [2];

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             ce_next;
  logic             run_evt;
  logic             step_evt;

  assign btn_raw = {btn_step_i, btn_run_i};

  // Stage p0/p1: two-flop synchronizer, then debounce and rising-edge press detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != stable[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            stable[i] <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign run_evt  = press[BTN_RUN];
  assign step_evt = press[BTN_STEP];

  // Halt outranks run, and run outranks step; every pulse is decided one cycle ahead
  always_comb begin
    state_next = state;
    div_next   = div;
    ce_next    = 1'b0;
    case (state)
      ST_STOPPED: begin
        if (cpu_halt_i) begin
          state_next = ST_HALTED;
        end else if (run_evt) begin
          state_next = ST_RUNNING;
          div_next   = '0;
        end else if (step_evt) begin
          ce_next = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (cpu_halt_i) begin
          state_next = ST_HALTED;
        end else if (run_evt) begin
          state_next = ST_STOPPED;
          div_next   = '0;
        end else if (div == DIV_LAST) begin
          ce_next  = 1'b1;
          div_next = '0;
        end else begin
          div_next = div + 1'b1;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_STOPPED;
        div_next   = '0;
      end
    endcase
  end

  // Stage p2: state and all outputs registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_STOPPED;
      div       <= '0;
      cpu_ce_o  <= 1'b0;
      running_o <= 1'b0;
      halted_o  <= 1'b0;
    end else begin
      state     <= state_next;
      div       <= div_next;
      cpu_ce_o  <= ce_next;
      running_o <= (state_next == ST_RUNNING);
      halted_o  <= (state_next == ST_HALTED);
    end
  end

`ifdef CYCLE_COUNTER_EN
  logic [15:0] cycle_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 16'h0000;
    end else if (ce_next) begin
      cycle_count <= cycle_count + 16'h0001;
    end
  end

  assign cycle_count_o = cycle_count;
`else
  assign cycle_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller (DEBOUNCE_CYCLES=4, RUN_DIV=3, plus a RUN_DIV=1 instance).
module tb_cpu_step_controller;

`ifdef CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_run, btn_step, cpu_halt;
  logic        ce, running, halted;
  logic [15:0] count;
  logic        f_btn_run, f_btn_step, f_halt;
  logic        f_ce, f_running, f_halted;
  logic [15:0] f_count;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  always #5 clk = ~clk;

  cpu_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3)) u_dut (
    .clk(clk), .reset(reset), .btn_run_i(btn_run), .btn_step_i(btn_step),
    .cpu_halt_i(cpu_halt), .cpu_ce_o(ce), .running_o(running), .halted_o(halted),
    .cycle_count_o(count)
  );

  cpu_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1)) u_fast (
    .clk(clk), .reset(reset), .btn_run_i(f_btn_run), .btn_step_i(f_btn_step),
    .cpu_halt_i(f_halt), .cpu_ce_o(f_ce), .running_o(f_running), .halted_o(f_halted),
    .cycle_count_o(f_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; btn_run = 1'b0; btn_step = 1'b0; cpu_halt = 1'b0;
    f_btn_run = 1'b0; f_btn_step = 1'b0; f_halt = 1'b0;

    // 1: reset then idle
    tick();
    chk("rst_ce", ce, 0); chk("rst_run", running, 0);
    chk("rst_halt", halted, 0); chk("rst_cnt", count, 0);
    repeat (4) tick();
    reset = 1'b0;
    pulses = 0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      pulses += int'(ce);
    end
    chk("idle_pulses", 16'(pulses), 0);
    chk("idle_run", running, 0); chk("idle_halt", halted, 0);

    // 2: single step held 12 cycles, then bounce
    for (int t = 1; t <= 30; t++) begin
      btn_step = (t <= 12);
      tick();
      chk("step_ce", ce, 16'(t == 8));
      chk("step_run", running, 0);
    end
    for (int t = 1; t <= 40; t++) begin
      btn_step = (t <= 20) && (((t - 1) / 2) % 2 == 0);
      tick();
      chk("bounce_ce", ce, 0);
    end
    chk("step_cnt", count, CNT_EN ? 16'd1 : 16'd0);

    // 3: run, then stop on a divider-terminal cycle
    pulses = 0;
    for (int t = 1; t <= 80; t++) begin
      btn_run = (t <= 10) || (t >= 40 && t <= 49);
      tick();
      chk("run_running", running, 16'(t >= 8 && t <= 46));
      chk("run_ce", ce, 16'(t >= 11 && t <= 44 && (t - 8) % 3 == 0));
      if (t >= 9 && t <= 38) pulses += int'(ce);
    end
    chk("run_pulses30", 16'(pulses), 10);
    chk("run_cnt", count, CNT_EN ? 16'd13 : 16'd0);

    // 4: halt on the terminal cycle, buttons ignored, reset exits
    for (int t = 1; t <= 70; t++) begin
      btn_run  = (t <= 10) || (t >= 50 && t <= 59);
      btn_step = (t >= 30 && t <= 39);
      cpu_halt = (t >= 17);
      tick();
      chk("halt_ce", ce, 16'(t == 11 || t == 14));
      chk("halt_running", running, 16'(t >= 8 && t <= 16));
      chk("halt_halted", halted, 16'(t >= 17));
    end
    chk("halt_cnt", count, CNT_EN ? 16'd15 : 16'd0);
    reset = 1'b1; cpu_halt = 1'b0;
    tick();
    chk("hrst_ce", ce, 0); chk("hrst_run", running, 0);
    chk("hrst_halt", halted, 0); chk("hrst_cnt", count, 0);
    reset = 1'b0;
    tick();

    // 5: run and step together, then reset mid-run
    for (int t = 1; t <= 25; t++) begin
      btn_run  = (t <= 10);
      btn_step = (t <= 10);
      reset    = (t == 17);
      tick();
      chk("both_ce", ce, 16'(t == 11 || t == 14));
      chk("both_running", running, 16'(t >= 8 && t < 17));
      if (t == 17) begin
        chk("mrst_halt", halted, 0);
        chk("mrst_cnt", count, 0);
      end
    end
    reset = 1'b0;

    // 6: five step presses, then counter wrap on the RUN_DIV=1 instance
    for (int p = 0; p < 5; p++) begin
      for (int t = 1; t <= 18; t++) begin
        btn_step = (t <= 8);
        tick();
        chk("step5_ce", ce, 16'(t == 8));
      end
    end
    chk("step5_cnt", count, CNT_EN ? 16'd5 : 16'd0);

    for (int t = 1; t <= 10; t++) begin
      f_btn_run = 1'b1;
      tick();
      chk("fast_ce", f_ce, 16'(t >= 9));
      chk("fast_running", f_running, 16'(t >= 8));
    end
    f_btn_run = 1'b0;
    chk("fast_cnt2", f_count, CNT_EN ? 16'd2 : 16'd0);
    if (CNT_EN) begin
      repeat (65533) tick();
      chk("wrap_ffff", f_count, 16'hFFFF);
      tick();
      chk("wrap_zero", f_count, 16'h0000);
      chk("wrap_ce", f_ce, 1);
      tick();
      chk("wrap_one", f_count, 16'h0001);
    end else begin
      repeat (20) tick();
      chk("nocnt_fast", f_count, 0);
      chk("nocnt_ce", f_ce, 1);
    end
    chk("fast_halted", f_halted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
